debug_uart_tx: RTL and testbench

Serial transmitter for the CPU debug ports: snapshots the seven 8-bit debug bytes the core exposes and sends them to the host-side serial debugger as one framed UART burst. Sits beside the core at the top level, fed by the debug port bus, and drives the board's UART TX pin. It is the sending end of the debug link whose receiving end is the host debugger.

---
 rtl/debug_uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 44 ++++
 rtl/debug_uart_tx.sv | 193 +++++++++++++++++++
 tb/tb_debug_uart_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_pkg.sv
// Shared types and constants for the debug UART transmitter.
// Provides the FSM state enum, the default frame header byte and a helper
// returning the number of bytes in one frame.
package debug_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Header byte + port bytes + optional checksum byte.
    function automatic int unsigned frame_bytes(input int unsigned num_ports, input bit csum_en);
        return 32'd1 + num_ports + 32'(csum_en);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// UART bit-period timer.
// Counts 0..CLKS_PER_BIT-1 and raises bit_end for exactly one cycle on the
// last count of every bit; start holds the count at zero so the first bit
// after start lasts a full CLKS_PER_BIT cycles.
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset
//   start    hold/reload the counter at zero
//   bit_end  registered one-cycle tick on the last cycle of a bit
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic bit_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on start or at the end of each bit, otherwise count up.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (start || bit_end) begin
            cnt_d = '0;
        end
    end

    // bit_end is registered alongside the count so it marks cnt_q == LAST.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_end <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_end <= (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug-port UART transmitter.
// Snapshots NUM_PORTS debug bytes on a trigger and sends them as one 8N1,
// LSB-first burst: SYNC_BYTE, port bytes 0..NUM_PORTS-1, then an optional
// XOR checksum byte when DEBUG_UART_CHECKSUM_EN is defined.
// Ports:
//   clk_i         clock
//   reset_i       synchronous active-low reset
//   trigger_i     request a snapshot and frame
//   ports_i       debug bytes, byte k at [8k+7:8k]
//   tx_o          UART line, idle high (registered)
//   busy_o        frame in progress
//   frame_done_o  one-cycle pulse on the last stop-bit cycle
//   drop_cnt_o    saturating count of ignored triggers
// Build option: DEBUG_UART_CHECKSUM_EN appends the checksum byte.
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_PORTS    = 7,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   trigger_i,
    input  logic [8*NUM_PORTS-1:0] ports_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [7:0]             drop_cnt_o
);

`ifdef DEBUG_UART_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int unsigned NUM_BYTES = frame_bytes(NUM_PORTS, CSUM_EN);
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] byte_idx_q;
    logic [IDX_W-1:0] byte_idx_d;
    logic [2:0]       bit_idx_q;
    logic [2:0]       bit_idx_d;
    logic [7:0]       snap_q [NUM_PORTS];
    logic [7:0]       cur_byte_c;
    logic             bit_end;
    logic             capture_c;
    logic             done_c;
    logic             drop_c;
    logic             tx_c;

`ifdef DEBUG_UART_CHECKSUM_EN
    logic [7:0] csum_q;
    logic [7:0] csum_in_c;

    // Checksum of the bytes being captured, so it is ready before it is sent.
    always_comb begin
        csum_in_c = SYNC_BYTE;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            csum_in_c = csum_in_c ^ ports_i[8*k +: 8];
        end
    end
`endif

    // Timer runs only while a frame is in progress.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk_i),
        .rst_n  (reset_i),
        .start  (state_q == ST_IDLE),
        .bit_end(bit_end)
    );

    // Byte currently on the line: header, snapshot byte, or checksum.
    always_comb begin
        cur_byte_c = SYNC_BYTE;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            if (byte_idx_q == IDX_W'(k + 1)) begin
                cur_byte_c = snap_q[k];
            end
        end
`ifdef DEBUG_UART_CHECKSUM_EN
        if (byte_idx_q == LAST_IDX) begin
            cur_byte_c = csum_q;
        end
`endif
    end

    // Next-state and line value. A trigger on the final stop-bit cycle
    // restarts immediately so held triggers give gapless frames.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        capture_c  = 1'b0;
        done_c     = 1'b0;
        drop_c     = 1'b0;
        tx_c       = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // The cycle showing frame_done_o still counts as busy.
                if (trigger_i && !frame_done_o) begin
                    capture_c  = 1'b1;
                    byte_idx_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                tx_c = 1'b0;
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_c = cur_byte_c[bit_idx_q];
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                tx_c = 1'b1;
                if (bit_end) begin
                    if (byte_idx_q == LAST_IDX) begin
                        done_c = 1'b1;
                        if (trigger_i) begin
                            capture_c  = 1'b1;
                            byte_idx_d = '0;
                            state_d    = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        state_d    = ST_START;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (trigger_i && !capture_c) begin
            drop_c = 1'b1;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= '0;
            bit_idx_q    <= '0;
            tx_o         <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            drop_cnt_o   <= '0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            tx_o         <= tx_c;
            busy_o       <= (state_q != ST_IDLE);
            frame_done_o <= done_c;
            if (drop_c && (drop_cnt_o != 8'hFF)) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

    // Snapshot frozen for the whole frame; data-only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (capture_c) begin
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                snap_q[k] <= ports_i[8*k +: 8];
            end
`ifdef DEBUG_UART_CHECKSUM_EN
            csum_q <= csum_in_c;
`endif
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx with CLKS_PER_BIT=4, NUM_PORTS=7.
module tb_debug_uart_tx;

    localparam int C  = 4;
    localparam int NP = 7;
`ifdef DEBUG_UART_CHECKSUM_EN
    localparam int NB = NP + 2;
`else
    localparam int NB = NP + 1;
`endif
    localparam int F  = NB * 10 * C;

    logic            clk;
    logic            reset_i;
    logic            trigger_i;
    logic [8*NP-1:0] ports_i;
    logic            tx_o;
    logic            busy_o;
    logic            frame_done_o;
    logic [7:0]      drop_cnt_o;

    int total;
    int bad;
    int exp_drop;

    logic [7:0] exp_bytes [NB];
    logic       line_s [0:F+2];
    logic       busy_s [0:F+2];
    logic       done_s [0:F+2];

    debug_uart_tx #(
        .CLKS_PER_BIT(C),
        .NUM_PORTS   (NP),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .trigger_i   (trigger_i),
        .ports_i     (ports_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq_ports();
        for (int k = 0; k < NP; k++) ports_i[8*k +: 8] = 8'(k + 1);
    endtask

    // Expected frame for the sequential ports 01..07: A5 01..07 [A5].
    task automatic expect_seq();
        exp_bytes[0] = 8'hA5;
        for (int k = 0; k < NP; k++) exp_bytes[k+1] = 8'(k + 1);
`ifdef DEBUG_UART_CHECKSUM_EN
        exp_bytes[NB-1] = 8'hA5;
`endif
    endtask

    // Expected line level k cycles after the accepting edge (k = 1..F).
    function automatic logic exp_bit(input int k);
        int p;
        int b;
        int s;
        logic [7:0] v;
        p = k - 1;
        b = p / (10 * C);
        s = (p % (10 * C)) / C;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        v = exp_bytes[b];
        return v[s-1];
    endfunction

    function automatic int bit_errs();
        int n;
        n = 0;
        for (int k = 1; k <= F; k++) if (line_s[k] !== exp_bit(k)) n++;
        return n;
    endfunction

    function automatic logic [7:0] dec_byte(input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = line_s[1 + b*10*C + (i+1)*C + C/2];
        return v;
    endfunction

    function automatic int done_hits();
        int n;
        n = 0;
        for (int k = 1; k <= F + 2; k++) if (done_s[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int busy_errs();
        int n;
        n = 0;
        for (int k = 1; k <= F + 2; k++) if (busy_s[k] !== ((k <= F) ? 1'b1 : 1'b0)) n++;
        return n;
    endfunction

    // Trigger sampled by the next edge (edge T); returns at T + #1.
    task automatic fire();
        trigger_i = 1'b1;
        step();
        trigger_i = 1'b0;
    endtask

    // Record cycles T+1..T+F+2, optionally disturbing inputs along the way.
    task automatic collect(input int ff_at, input int trig_every, input int ntrig,
                           input int hold_n, input bit done_trig);
        for (int k = 1; k <= F + 2; k++) begin
            step();
            line_s[k] = tx_o;
            busy_s[k] = busy_o;
            done_s[k] = frame_done_o;
            if (k == ff_at) ports_i = '1;
            trigger_i = 1'b0;
            if (trig_every > 0 && (k % trig_every) == 0 && (k / trig_every) <= ntrig) trigger_i = 1'b1;
            if (k <= hold_n) trigger_i = 1'b1;
            if (done_trig && k == F) trigger_i = 1'b1;
        end
    endtask

    task automatic test_reset();
        int errs;
        reset_i   = 1'b0;
        trigger_i = 1'b0;
        ports_i   = '0;
        repeat (3) step();
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done_o); end
        total++; if (drop_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
        reset_i = 1'b1;
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || drop_cnt_o !== 8'd0 || frame_done_o !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL idle_100: %0d bad cycles, want 0", errs); end
    endtask

    task automatic test_single_frame();
        load_seq_ports();
        expect_seq();
        step();
        fire();
        total++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL latency_T: tx=%b busy=%b want 1/0", tx_o, busy_o); end
        collect(0, 0, 0, 0, 1'b1);
        exp_drop = exp_drop + 1;
        total++; if (line_s[1] !== 1'b0 || busy_s[1] !== 1'b1) begin bad++; $display("FAIL latency_T1: tx=%b busy=%b want 0/1", line_s[1], busy_s[1]); end
        total++; if (bit_errs() != 0) begin bad++; $display("FAIL single_bits: %0d wrong cycles want 0", bit_errs()); end
        for (int b = 0; b < NB; b++) begin
            total++; if (dec_byte(b) !== exp_bytes[b]) begin bad++; $display("FAIL single_byte%0d: got %h want %h", b, dec_byte(b), exp_bytes[b]); end
        end
        total++; if (done_s[F] !== 1'b1 || done_hits() != 1) begin bad++; $display("FAIL single_done: at_F=%b hits=%0d want 1/1", done_s[F], done_hits()); end
        total++; if (busy_errs() != 0) begin bad++; $display("FAIL single_busy: %0d wrong cycles want 0", busy_errs()); end
        total++; if (line_s[F+1] !== 1'b1 || line_s[F+2] !== 1'b1) begin bad++; $display("FAIL single_idle: got %b%b want 11", line_s[F+1], line_s[F+2]); end
        total++; if (drop_cnt_o !== 8'(exp_drop)) begin bad++; $display("FAIL done_cycle_drop: got %0d want %0d", drop_cnt_o, exp_drop); end
    endtask

    task automatic test_snapshot();
        load_seq_ports();
        expect_seq();
        fire();
        collect(50, 0, 0, 0, 1'b0);
        total++; if (bit_errs() != 0) begin bad++; $display("FAIL snapshot_bits: %0d wrong cycles want 0", bit_errs()); end
        for (int b = 0; b < NB; b++) begin
            total++; if (dec_byte(b) !== exp_bytes[b]) begin bad++; $display("FAIL snapshot_byte%0d: got %h want %h", b, dec_byte(b), exp_bytes[b]); end
        end
        load_seq_ports();
    endtask

    task automatic test_drop();
        fire();
        collect(0, 30, 3, 0, 1'b0);
        exp_drop = exp_drop + 3;
        total++; if (drop_cnt_o !== 8'(exp_drop)) begin bad++; $display("FAIL drop_three: got %0d want %0d", drop_cnt_o, exp_drop); end
        total++; if (bit_errs() != 0) begin bad++; $display("FAIL drop_bits: %0d wrong cycles want 0", bit_errs()); end
        total++; if (done_s[F] !== 1'b1 || done_hits() != 1) begin bad++; $display("FAIL drop_done: at_F=%b hits=%0d want 1/1", done_s[F], done_hits()); end
    endtask

    task automatic test_drop_sat();
        fire();
        collect(0, 0, 0, 300, 1'b0);
        exp_drop = 255;
        total++; if (drop_cnt_o !== 8'd255) begin bad++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt_o); end
        total++; if (bit_errs() != 0) begin bad++; $display("FAIL sat_bits: %0d wrong cycles want 0", bit_errs()); end
    endtask

    task automatic test_back_to_back();
        logic tx_f;
        logic done_f;
        logic tx_f1;
        logic busy_f1;
        int   found;
        trigger_i = 1'b1;
        step();
        tx_f = 1'bx; done_f = 1'bx; tx_f1 = 1'bx; busy_f1 = 1'bx;
        for (int k = 1; k <= F + 1; k++) begin
            step();
            if (k <= F) line_s[k] = tx_o;
            if (k == F) begin tx_f = tx_o; done_f = frame_done_o; end
            if (k == F + 1) begin tx_f1 = tx_o; busy_f1 = busy_o; end
        end
        trigger_i = 1'b0;
        total++; if (bit_errs() != 0) begin bad++; $display("FAIL b2b_bits: %0d wrong cycles want 0", bit_errs()); end
        total++; if (tx_f !== 1'b1 || done_f !== 1'b1) begin bad++; $display("FAIL b2b_end: tx=%b done=%b want 1/1", tx_f, done_f); end
        total++; if (tx_f1 !== 1'b0 || busy_f1 !== 1'b1) begin bad++; $display("FAIL b2b_start: tx=%b busy=%b want 0/1", tx_f1, busy_f1); end
        found = -1;
        for (int k = F + 2; k <= 2*F + 10; k++) begin
            step();
            if (frame_done_o === 1'b1 && found < 0) found = k;
        end
        total++; if (found != 2*F) begin bad++; $display("FAIL b2b_second_done: at T+%0d want T+%0d", found, 2*F); end
        total++; if (busy_o !== 1'b0 || tx_o !== 1'b1) begin bad++; $display("FAIL b2b_idle: busy=%b tx=%b want 0/1", busy_o, tx_o); end
        total++; if (drop_cnt_o !== 8'(exp_drop)) begin bad++; $display("FAIL b2b_drop: got %0d want %0d", drop_cnt_o, exp_drop); end
    endtask

    task automatic test_reset_mid();
        fire();
        repeat (100) step();
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy_o); end
        reset_i = 1'b0;
        step();
        exp_drop = 0;
        total++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL mid_reset: tx=%b busy=%b want 1/0", tx_o, busy_o); end
        total++; if (drop_cnt_o !== 8'd0 || frame_done_o !== 1'b0) begin bad++; $display("FAIL mid_reset_cnt: drop=%0d done=%b want 0/0", drop_cnt_o, frame_done_o); end
        step();
        reset_i = 1'b1;
        step();
        fire();
        collect(0, 0, 0, 0, 1'b0);
        total++; if (bit_errs() != 0) begin bad++; $display("FAIL mid_frame_bits: %0d wrong cycles want 0", bit_errs()); end
        for (int b = 0; b < NB; b++) begin
            total++; if (dec_byte(b) !== exp_bytes[b]) begin bad++; $display("FAIL mid_byte%0d: got %h want %h", b, dec_byte(b), exp_bytes[b]); end
        end
        total++; if (done_s[F] !== 1'b1 || done_hits() != 1) begin bad++; $display("FAIL mid_done: at_F=%b hits=%0d want 1/1", done_s[F], done_hits()); end
        total++; if (busy_errs() != 0) begin bad++; $display("FAIL mid_busy: %0d wrong cycles want 0", busy_errs()); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        exp_drop = 0;
        test_reset();
        test_single_frame();
        test_snapshot();
        test_drop();
        test_drop_sat();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
